// File: rtl/alu_sequencer.sv
// alu_sequencer: frame-triggered micro-sequencer that owns the 8x16
// register file and steps the shared combinational Alu.
module alu_sequencer #(
    parameter int ADDR_W = 5,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_v_sync,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [15:0]       instr_data,
    output logic [15:0]       operand1,
    output logic [15:0]       operand2,
    output logic              carryIn,
    output logic              enableAlu,
    output logic              enableShift,
    output logic              enableLoad,
    output logic [2:0]        aluOperation,
    output logic [2:0]        shiftOperation,
    output logic [2:0]        loadOperation,
    input  logic [15:0]       result,
    input  logic              carryOut,
    input  logic [2:0]        rd_sel,
    output logic [15:0]       rd_data,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WRITE} state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       rf_q [NREG];
    logic              carry_q, carry_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic              vs_q, vs_prev_q;
    logic              trig, wr_en, drive;

    logic [1:0] cls;
    logic [2:0] op, dst, src1, src2;
    logic       usec, last;

    assign cls   = ir_q[15:14];
    assign op    = ir_q[13:11];
    assign dst   = ir_q[10:8];
    assign src1  = ir_q[7:5];
    assign src2  = ir_q[4:2];
    assign usec  = ir_q[1];
    assign last  = ir_q[0];

    assign trig  = vs_q & ~vs_prev_q;
    assign drive = (state_q == EXEC) || (state_q == WRITE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        wr_en   = 1'b0;
        if (trig && state_q != IDLE)
            ovr_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                pc_d = '0;
                if (trig) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                ir_d    = instr_data;
                state_d = EXEC;
            end
            EXEC: state_d = WRITE;
            WRITE: begin
                if (cls != 2'b11) begin
                    wr_en   = 1'b1;
                    carry_d = carryOut;
                end
                if (last || pc_q == '1) begin
                    pc_d    = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Alu drive is held across EXEC and WRITE so result is stable at the write edge
    always_comb begin
        operand1       = '0;
        operand2       = '0;
        carryIn        = 1'b0;
        enableAlu      = 1'b0;
        enableShift    = 1'b0;
        enableLoad     = 1'b0;
        aluOperation   = '0;
        shiftOperation = '0;
        loadOperation  = '0;
        if (drive) begin
            operand1 = rf_q[src1];
            operand2 = rf_q[src2];
            carryIn  = usec & carry_q;
            unique case (cls)
                2'b00: begin
                    enableAlu    = 1'b1;
                    aluOperation = op;
                end
                2'b01: begin
                    enableShift    = 1'b1;
                    shiftOperation = op;
                end
                2'b10: begin
                    enableLoad    = 1'b1;
                    loadOperation = op;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
            ovr_q     <= ovr_d;
            vs_q      <= vga_v_sync;
            vs_prev_q <= vs_q;
            if (wr_en)
                rf_q[dst] <= result;
        end
    end

    assign instr_addr = pc_q;
    assign rd_data    = rf_q[rd_sel];
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Frame-synchronous micro-sequencer that owns the 8x16 register file and drives the shared combinational Alu.
- On each rising edge of vga_v_sync it fetches 16-bit instructions from an external synchronous program ROM.
- Per instruction: sequences operands into the Alu, then writes result and carry back.
- Exposes a combinational read port so the registerToPixel display path can show register contents during active video.

Parameters:
- ADDR_W, 5, program ROM address width; program length max 2^ADDR_W instructions.
- NREG, 8, register count (fixed at 8; 3-bit register fields).

Ports:
- clk  input  1  pixel/system clock (PLL output).
- reset_n  input  1  asynchronous, active-low reset.
- vga_v_sync  input  1  frame trigger; asynchronous to nothing, same clk domain, level signal.
- instr_addr  output  ADDR_W  program ROM address.
- instr_data  input  16  ROM data, valid one clk after instr_addr changes.
- operand1  output  16  to Alu operand1.
- operand2  output  16  to Alu operand2.
- carryIn  output  1  to Alu carryIn.
- enableAlu, enableShift, enableLoad  output  1 each  Alu unit selects, one-hot or all 0.
- aluOperation, shiftOperation, loadOperation  output  3 each  Alu op fields.
- result  input  16  Alu result.
- carryOut  input  1  Alu carry out.
- rd_sel  input  3  display read select.
- rd_data  output  16  register[rd_sel], combinational.
- busy  output  1  program running.
- overrun  output  1  sticky: frame trigger arrived while busy.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (reset_n).
- Reset values:
  - All registers, pc, carry flag, busy and overrun = 0; state = IDLE.
  - instr_addr = 0; operands = 0; all enables = 0; op fields = 0.
- Trigger:
  - vga_v_sync is registered once; a rising edge is prev==0 && cur==1.
  - In IDLE, a rising edge moves to FETCH and sets busy the next cycle.
  - In any other state, a rising edge sets overrun and is otherwise ignored.
- Instruction format:
  - [15:14] class: 00 ALU, 01 shift, 10 load, 11 nop.
  - [13:11] op; [10:8] dst; [7:5] src1; [4:2] src2.
  - [1] usec: carryIn = carry flag when 1, else 0.
  - [0] last.
- FSM (3 cycles per instruction):
  - IDLE: instr_addr = pc = 0.
  - FETCH: instr_addr = pc; wait one cycle for ROM data; latch instr_data into IR on exit.
  - EXEC:
    - Drive operand1 = reg[src1], operand2 = reg[src2], carryIn per usec.
    - Assert exactly the enable selected by class; copy op to the matching op field, others 0.
    - Class 11 asserts no enable.
  - WRITE:
    - Hold the EXEC drive. Unless class 11: reg[dst] <= result and carry flag <= carryOut.
    - Then deassert all enables.
    - If last==1 or pc == 2^ADDR_W-1: pc <= 0, busy <= 0, go to IDLE.
    - Else pc <= pc+1 and go to FETCH.
- Register file:
  - Read ports are combinational.
  - dst==src in one instruction reads the old value, because the write occurs at the end of WRITE.
  - rd_data during a WRITE-cycle write returns the pre-write value.
- Arithmetic: all 16-bit, no saturation; the sequencer does not interpret result.
- Overrun:
  - Cleared only by reset.
  - Unaffected by rd_sel.
  - Trigger during the WRITE of the last instruction counts as overrun; the program does not restart until the next edge.
- vga_v_sync held high across a program completion does not restart (edge-only).
- Reset mid-program aborts immediately to reset values, register contents included.

Test Plan:
- Reset, then hold reset_n=0 with vga_v_sync toggling -> busy=0, instr_addr=0, all enables 0, rd_data=0 for every rd_sel.
- ROM[0] = ALU op 3'b001 dst1 src1 src2 (not last); ROM[1] = nop last; Alu model returns 16'h0005 carry 1.
  - One vsync edge -> busy high for 6 cycles, then 0.
  - reg1 = 16'h0005, carry flag = 1, instr_addr sequence 0,0,0,1,1,1.
- Load instruction, usec=1 after a previous carryOut=1 -> in EXEC enableLoad=1, carryIn=1, enableAlu=enableShift=0, loadOperation=op.
- Program with no last bit, ADDR_W=2 -> exactly 4 instructions execute, then IDLE with pc=0.
- Second vsync edge during busy -> overrun=1 and the program is not restarted; overrun stays 1 after the next normal frame.
- Assert reset_n=0 during EXEC of instruction 2 -> all outputs and registers 0 within the same cycle (async); the next vsync edge restarts at address 0.
